// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multdiv scheduler: state encoding,
// op codes, requester ID width and parameter defaults.
package multdiv_sched_pkg;

  localparam int ID_WIDTH               = 1;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_scheduler_if.sv
// Bundles the two requester ports, the response port and the multdiv-side port.
// master = scheduler view, slave = requesters/consumer/multdiv view.
interface multdiv_scheduler_if
  import multdiv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_WIDTH-1:0]   resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_exception;

  logic [DATA_WIDTH-1:0] md_operandA;
  logic [DATA_WIDTH-1:0] md_operandB;
  logic                  md_ctrl_MULT;
  logic                  md_ctrl_DIV;
  logic [DATA_WIDTH-1:0] md_result;
  logic                  md_exception;
  logic                  md_resultRDY;

  modport master (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    input  md_result, md_exception, md_resultRDY,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_exception,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );

  modport slave (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    output md_result, md_exception, md_resultRDY,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_exception,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV
  );

endinterface

// File: rtl/multdiv_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; on contention the requester that did
// not win last time is granted. Grant is one-hot or zero.
module rr_arbiter2 (
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Arbitrates two requesters onto one multdiv unit and sequences each operation.
// Optional WAIT-state timeout is built when MULTDIV_TIMEOUT_EN is defined.
//
//  state | meaning
//  IDLE  | arbitrating, readies may be asserted
//  ISSUE | one-cycle ctrl_MULT/ctrl_DIV pulse to multdiv
//  WAIT  | waiting for md_resultRDY (or timeout)
//  RESP  | response held until resp_ready
module multdiv_scheduler
  import multdiv_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 clock,
  input logic                 reset_n,
  multdiv_scheduler_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            grant;
  logic                  accept;
  logic                  last_grant;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  exc_q;
  logic                  issue_mult;
  logic                  issue_div;
  logic                  capture;
  logic                  timeout;

  rr_arbiter2 u_arb (
    .en         (state == IDLE),
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept = |grant;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !bus.md_resultRDY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the WAIT cycle that brings the count to TIMEOUT_CYCLES; RDY wins a tie.
  assign timeout = (state == WAIT) && !bus.md_resultRDY &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    issue_mult = 1'b0;
    issue_div  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_mult = (op_q == OP_MULT);
        issue_div  = (op_q == OP_DIV);
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (bus.md_resultRDY) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (timeout) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_MULT;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      last_grant <= 1'b1;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= grant[1] ? bus.req1_op : bus.req0_op;
        a_q        <= grant[1] ? bus.req1_a  : bus.req0_a;
        b_q        <= grant[1] ? bus.req1_b  : bus.req0_b;
        id_q       <= ID_WIDTH'(grant[1]);
        last_grant <= grant[1];
      end
      if (capture) begin
        result_q <= bus.md_result;
        exc_q    <= bus.md_exception;
      end else if (timeout) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end
  end

  assign bus.req0_ready     = grant[0];
  assign bus.req1_ready     = grant[1];
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_id        = id_q;
  assign bus.resp_result    = result_q;
  assign bus.resp_exception = exc_q;
  assign bus.md_operandA    = a_q;
  assign bus.md_operandB    = b_q;
  assign bus.md_ctrl_MULT   = issue_mult;
  assign bus.md_ctrl_DIV    = issue_div;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler with a programmable-latency multdiv model.
module tb_multdiv_scheduler;
  import multdiv_sched_pkg::*;

  logic clock;
  logic reset_n;

  multdiv_scheduler_if #(.DATA_WIDTH(32)) bus ();

  multdiv_scheduler #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_lat = 17;
  bit model_never = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {25'd0, bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id,
            bus.resp_exception, bus.resp_result, bus.md_operandA, bus.md_operandB,
            bus.md_ctrl_MULT, bus.md_ctrl_DIV};
  endfunction

  // multdiv model: RDY is high in the cycle L cycles after the ctrl pulse cycle
  initial begin : mdl
    int          cnt;
    bit          busy;
    logic [31:0] pend_res;
    logic        pend_exc;
    cnt = 0; busy = 0; pend_res = '0; pend_exc = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    forever begin
      @(negedge clock);
      bus.md_resultRDY = 1'b0;
      if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
        if (bus.md_ctrl_MULT) begin
          pend_res = bus.md_operandA * bus.md_operandB;
          pend_exc = 1'b0;
        end else if (bus.md_operandB == 0) begin
          pend_res = '0;
          pend_exc = 1'b1;
        end else begin
          pend_res = bus.md_operandA / bus.md_operandB;
          pend_exc = 1'b0;
        end
        busy = !model_never;
        cnt  = model_lat;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          bus.md_resultRDY = 1'b1;
          bus.md_result    = pend_res;
          bus.md_exception = pend_exc;
        end
      end
    end
  end

  task automatic accept_req(input int id, input logic op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 0;
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("accept_bound", ok, 1);
  endtask

  // cycles = negedge index (1 = first after acceptance edge) where resp_valid is seen
  task automatic wait_resp(output int cycles, output int nmult, output int ndiv,
                           output int nready, output logic first_mult, output logic first_div);
    cycles = 0; nmult = 0; ndiv = 0; nready = 0; first_mult = 1'b0; first_div = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) begin
        first_mult = bus.md_ctrl_MULT;
        first_div  = bus.md_ctrl_DIV;
      end
      nmult += int'(bus.md_ctrl_MULT);
      ndiv  += int'(bus.md_ctrl_DIV);
      nready += int'(bus.req0_ready) + int'(bus.req1_ready);
      if (bus.resp_valid) begin
        cycles = k;
        break;
      end
    end
    check("resp_wait_bound", cycles != 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, nm, nd, nr, cnt_v, cnt_r, cnt_c;
    logic fm, fd;
    bit   ok;
    int   exp_res [2];

    reset_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("reset_outputs", all_outs(), 128'd0);
    reset_n = 1'b1;

    // 1: multiply on requester 0, latency 17
    model_lat = 17;
    accept_req(0, OP_MULT, 32'd6, 32'd7);
    wait_resp(cyc, nm, nd, nr, fm, fd);
    check("t1_mult_at_issue", fm, 1);
    check("t1_div_at_issue", fd, 0);
    check("t1_mult_pulses", nm, 1);
    check("t1_div_pulses", nd, 0);
    check("t1_latency", cyc, 19);
    check("t1_resp_id", bus.resp_id, 0);
    check("t1_result", bus.resp_result, 42);
    check("t1_exception", bus.resp_exception, 0);
    check("t1_operand_hold", {bus.md_operandA, bus.md_operandB}, {32'd6, 32'd7});
    @(posedge clock); #1;

    // 2: divide by zero on requester 1
    model_lat = 5;
    accept_req(1, OP_DIV, 32'd100, 32'd0);
    wait_resp(cyc, nm, nd, nr, fm, fd);
    check("t2_div_at_issue", fd, 1);
    check("t2_div_pulses", nd, 1);
    check("t2_mult_pulses", nm, 0);
    check("t2_latency", cyc, 7);
    check("t2_resp_id", bus.resp_id, 1);
    check("t2_exception", bus.resp_exception, 1);
    @(posedge clock); #1;

    // 3: contention, both valid every cycle
    model_lat = 3;
    exp_res[0] = 15;
    exp_res[1] = 14;
    bus.req0_valid = 1'b1; bus.req0_op = OP_MULT; bus.req0_a = 32'd3;   bus.req0_b = 32'd5;
    bus.req1_valid = 1'b1; bus.req1_op = OP_DIV;  bus.req1_a = 32'd100; bus.req1_b = 32'd7;
    for (int i = 0; i < 4; i++) begin
      ok = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (bus.req0_ready || bus.req1_ready) begin
          ok = 1;
          break;
        end
      end
      check("t3_grant_bound", ok, 1);
      check("t3_grant", {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clock); #1;
      wait_resp(cyc, nm, nd, nr, fm, fd);
      check("t3_latency", cyc, 5);
      check("t3_no_ready_in_flight", nr, 0);
      check("t3_resp_id", bus.resp_id, i % 2);
      check("t3_result", bus.resp_result, exp_res[i % 2]);
      @(posedge clock); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // 4: backpressure with requester 1 waiting
    model_lat = 4;
    bus.resp_ready = 1'b0;
    accept_req(0, OP_MULT, 32'd9, 32'd9);
    bus.req1_valid = 1'b1; bus.req1_op = OP_MULT; bus.req1_a = 32'd2; bus.req1_b = 32'd3;
    wait_resp(cyc, nm, nd, nr, fm, fd);
    check("t4_latency", cyc, 6);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("t4_hold", {bus.resp_valid, bus.resp_id, bus.resp_exception,
                        bus.req0_ready, bus.req1_ready, bus.resp_result},
                       {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd81});
    end
    bus.resp_ready = 1'b1;
    model_lat = 20;
    @(negedge clock);
    check("t4_idle_after_handshake", {bus.resp_valid, bus.req1_ready}, 2'b01);

    // 5: reset during WAIT, stale RDY must be ignored
    @(posedge clock); #1;
    bus.req1_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_reset_outputs", all_outs(), 128'd0);
    @(negedge clock);
    check("t5_reset_hold", all_outs(), 128'd0);
    reset_n = 1'b1;
    cnt_v = 0; cnt_r = 0; cnt_c = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      cnt_v += int'(bus.resp_valid);
      cnt_r += int'(bus.md_resultRDY);
      cnt_c += int'(bus.md_ctrl_MULT) + int'(bus.md_ctrl_DIV);
    end
    check("t5_stale_rdy_seen", cnt_r, 1);
    check("t5_no_resp_valid", cnt_v, 0);
    check("t5_no_ctrl", cnt_c, 0);
    model_lat = 2;
    accept_req(0, OP_DIV, 32'd50, 32'd5);
    wait_resp(cyc, nm, nd, nr, fm, fd);
    check("t5_next_latency", cyc, 4);
    check("t5_next_div", fd, 1);
    check("t5_next_result", {bus.resp_id, bus.resp_exception, bus.resp_result}, {1'b0, 1'b0, 32'd10});
    @(posedge clock); #1;

`ifdef MULTDIV_TIMEOUT_EN
    // 6: multdiv never answers, timeout after 8 WAIT cycles
    model_never = 1;
    accept_req(1, OP_MULT, 32'd3, 32'd3);
    wait_resp(cyc, nm, nd, nr, fm, fd);
    check("t6_latency", cyc, 10);
    check("t6_result", {bus.resp_id, bus.resp_exception, bus.resp_result}, {1'b1, 1'b1, 32'd0});
    @(posedge clock); #1;
    model_never = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_scheduler.md
Name: multdiv_scheduler

Overview:
Arbitrates two independent requesters onto the single shared multdiv unit and sequences each operation: latches the operands, issues one ctrl_MULT/ctrl_DIV pulse, then waits for data_resultRDY. It returns the result and exception to the winning requester, tagged with that requester's ID. It sits between the pipeline/issue logic and multdiv, and it is the only driver of multdiv's inputs.

Parameters:
DATA_WIDTH, 32, operand/result width; must match multdiv (32).
TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when MULTDIV_TIMEOUT_EN is defined.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 is accepted this cycle.
req0_op  in  1  0 = multiply, 1 = divide.
req0_a, req0_b  in  32 each  operands A and B.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
resp_valid  out  1  response holds valid data.
resp_ready  in  1  consumer accepts the response.
resp_id  out  1  ID of the requester that owns the response.
resp_result  out  32  result from multdiv.
resp_exception  out  1  exception from multdiv (or timeout, see Optional Feature).
md_operandA, md_operandB  out  32 each  drive multdiv data_operandA/B.
md_ctrl_MULT, md_ctrl_DIV  out  1 each  single-cycle start pulses to multdiv.
md_result  in  32  multdiv data_result.
md_exception  in  1  multdiv data_exception.
md_resultRDY  in  1  multdiv data_resultRDY.

Behaviour:
- Reset values: all outputs are 0; state = IDLE; last_grant = 1, so requester 0 wins the first contention.
- States and transitions:
  - IDLE -> ISSUE on handshake acceptance.
  - ISSUE -> WAIT after exactly one cycle.
  - WAIT -> RESP when md_resultRDY = 1.
  - RESP -> IDLE when resp_valid && resp_ready.
- Arbitration (IDLE only):
  - reqN_ready = (state == IDLE) && grant == N.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester that was not last_grant (round-robin).
  - last_grant updates only on acceptance.
  - reqN_ready is never asserted outside IDLE, and at most one ready is high per cycle.
- Acceptance at edge T: latch op, A, B and id. md_operandA/B take the latched values from T+1 and hold them stable until the next acceptance.
- ISSUE cycle (T+1): exactly one of md_ctrl_MULT / md_ctrl_DIV is high, selected by op, for exactly one cycle. Both pulses are never high together.
- md_resultRDY is ignored in IDLE, ISSUE and RESP; a stale RDY from an aborted operation is discarded.
- WAIT: on the first cycle with md_resultRDY = 1, capture md_result and md_exception into resp_result and resp_exception at that edge. From the next cycle, resp_valid = 1.
- Response registers: resp_valid, resp_id, resp_result and resp_exception are registered and stay stable while resp_valid && !resp_ready.
- Throughput: one operation in flight. Minimum accept-to-resp_valid latency is multdiv latency + 2 cycles. The next acceptance can occur in the cycle after the response handshake.
- Reset mid-operation: all state clears immediately and ctrl pulses drop. The multdiv internal state is not cleared, and any RDY it later produces is ignored per the rule above.
- Divide-by-zero is not detected here; md_exception passes through unchanged.

Optional Feature:
Macro: MULTDIV_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments on each WAIT cycle with md_resultRDY = 0.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with resp_result = 0 and resp_exception = 1.
  - An RDY arriving in the same cycle as the timeout wins: the normal result is captured.
- Not defined: no counter exists, and WAIT lasts until md_resultRDY.

Decomposition:
- Package multdiv_sched_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT, RESP.
  - op constants: OP_MULT = 1'b0, OP_DIV = 1'b1.
  - ID width constant: 1.
  - default TIMEOUT_CYCLES.
- One natural sub-module, rr_arbiter2: two-requester round-robin. Inputs are the valids, last_grant and an enable; outputs are the one-hot grant.

Test Plan:
- The bench uses a multdiv model with a programmable latency L.
1. Multiply: req0 op=0, A=6, B=7, L=17 -> md_ctrl_MULT high for exactly 1 cycle at T+1; resp_valid at T+19; resp_id=0, resp_result=42, resp_exception=0.
2. Divide with exception: req1 op=1, A=100, B=0, model exception=1 -> md_ctrl_DIV pulses once; resp_id=1, resp_exception=1.
3. Contention: both valid every cycle for 4 operations -> grants in order 0, 1, 0, 1; only one ready high per cycle; no second acceptance before a response handshake.
4. Backpressure: resp_ready held low for 10 cycles after resp_valid -> resp fields stable throughout, both reqN_ready = 0; after resp_ready = 1, state returns to IDLE.
5. Reset mid-WAIT: reset_n low 2 cycles, model RDY arrives after release -> all outputs 0, RDY ignored, no resp_valid; the next request completes normally.
6. With MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never asserts RDY -> resp_valid at accept + 10; resp_result=0, resp_exception=1.
